// File: rtl/keccak_absorb.sv
// keccak_absorb
// Absorb and padding front-end for a SHA3-512 core.
// Message words (little-endian, 64 bits) are XORed into the rate lanes of a
// locally held 1600-bit state. SHA-3 padding (0x06 ... 0x80) is applied on
// the final word, and the Keccak-f[1600] core is driven via a start/done pulse
// handshake. After the final permutation, lanes 0..7 are presented as the
// digest until acknowledged.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_data/in_bytes/in_last    message word, valid byte count (last only), last flag
//   in_valid/in_ready           word handshake
//   perm_start/perm_done        permutation request pulse / completion pulse
//   state_out/state_in          state to the core / permuted state from the core
//   digest/digest_valid/ack     512-bit result, held until digest_ack
// Lane (x,y) sits at bits [64*(5y+x)+63 : 64*(5y+x)].
module keccak_absorb #(
    parameter int RATE_LANES = 9,
    parameter int W          = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  in_data,
    input  logic [3:0]    in_bytes,
    input  logic          in_last,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          perm_start,
    input  logic          perm_done,
    output logic [1599:0] state_out,
    input  logic [1599:0] state_in,
    output logic [511:0]  digest,
    output logic          digest_valid,
    input  logic          digest_ack
);

    localparam int RATE_BITS = RATE_LANES * W;

    typedef enum logic [1:0] {ABSORB, PERM, PAD, DONE} fsm_t;

    fsm_t           fsm_reg;
    logic [1599:0]  st_reg;
    logic [3:0]     lane_reg;
    logic           final_reg;
    logic           pad_pending_reg;
    logic           perm_start_reg;

    logic [3:0]           n_eff;
    logic [6:0]           pad_pos;
    logic                 pad_in_block;
    logic                 in_xfer;
    logic                 lane_last;
    logic [W-1:0]         word_mask;
    logic [RATE_BITS-1:0] absorb_xor;
    logic [RATE_BITS-1:0] pad_xor;
    logic [RATE_BITS-1:0] padblk_xor;

    // Byte counts above 8 are clamped to a full word.
    assign n_eff   = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    // Byte position within the block where the 0x06 domain byte lands.
    assign pad_pos = {lane_reg, 3'b000} + {3'b000, n_eff};
    // Padding fits in this block unless the last word exactly fills it.
    assign pad_in_block = in_last && (pad_pos < 7'(RATE_LANES * 8));

    assign in_xfer   = in_valid && (fsm_reg == ABSORB);
    assign lane_last = (lane_reg == 4'(RATE_LANES - 1));

    // Non-last words pass whole; a last word keeps only its low n bytes.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            assign word_mask[8*gi +: 8] = (!in_last || (4'(gi) < n_eff)) ? 8'hff : 8'h00;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < RATE_LANES; gi++) begin : g_lane
            assign absorb_xor[W*gi +: W] = (lane_reg == 4'(gi)) ? (in_data & word_mask) : '0;

            // 0x06 at byte pad_pos and 0x80 at the last rate byte; these XOR
            // to 0x86 when both fall on the same byte.
            assign pad_xor[W*gi +: W] =
                ((pad_in_block && (pad_pos[6:3] == 4'(gi))) ? (64'h06 << {pad_pos[2:0], 3'b000}) : '0) ^
                ((pad_in_block && (gi == RATE_LANES - 1)) ? 64'h8000_0000_0000_0000 : '0);

            // Pad-only block after a message that exactly filled the rate.
            assign padblk_xor[W*gi +: W] =
                ((gi == 0) ? 64'h06 : '0) ^
                ((gi == RATE_LANES - 1) ? 64'h8000_0000_0000_0000 : '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg         <= ABSORB;
            st_reg          <= '0;
            lane_reg        <= '0;
            final_reg       <= 1'b0;
            pad_pending_reg <= 1'b0;
            perm_start_reg  <= 1'b0;
        end else begin
            perm_start_reg <= 1'b0;
            case (fsm_reg)
                ABSORB: begin
                    if (in_xfer) begin
                        st_reg[RATE_BITS-1:0] <= st_reg[RATE_BITS-1:0] ^ absorb_xor ^ pad_xor;
                        if (in_last) begin
                            lane_reg        <= '0;
                            final_reg       <= pad_in_block;
                            pad_pending_reg <= !pad_in_block;
                            perm_start_reg  <= 1'b1;
                            fsm_reg         <= PERM;
                        end else if (lane_last) begin
                            lane_reg       <= '0;
                            final_reg      <= 1'b0;
                            perm_start_reg <= 1'b1;
                            fsm_reg        <= PERM;
                        end else begin
                            lane_reg <= lane_reg + 4'd1;
                        end
                    end
                end
                PERM: begin
                    // A done pulse in the same cycle as our start pulse cannot
                    // belong to this permutation.
                    if (perm_done && !perm_start_reg) begin
                        st_reg <= state_in;
                        if (final_reg)
                            fsm_reg <= DONE;
                        else if (pad_pending_reg)
                            fsm_reg <= PAD;
                        else
                            fsm_reg <= ABSORB;
                    end
                end
                PAD: begin
                    st_reg[RATE_BITS-1:0] <= st_reg[RATE_BITS-1:0] ^ padblk_xor;
                    pad_pending_reg       <= 1'b0;
                    final_reg             <= 1'b1;
                    perm_start_reg        <= 1'b1;
                    fsm_reg               <= PERM;
                end
                DONE: begin
                    if (digest_ack) begin
                        st_reg          <= '0;
                        lane_reg        <= '0;
                        final_reg       <= 1'b0;
                        pad_pending_reg <= 1'b0;
                        fsm_reg         <= ABSORB;
                    end
                end
                default: fsm_reg <= ABSORB;
            endcase
        end
    end

    assign in_ready     = (fsm_reg == ABSORB);
    assign digest_valid = (fsm_reg == DONE);
    assign perm_start   = perm_start_reg;
    assign state_out    = st_reg;
    assign digest       = st_reg[511:0];

endmodule

// File: tb/tb_keccak_absorb.sv
// Testbench for keccak_absorb: directed message vectors, a bench-driven
// permutation core returning chosen states, and inline checks per scenario.
module tb_keccak_absorb;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   in_data = '0;
    logic [3:0]    in_bytes = '0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          perm_start;
    logic          perm_done = 1'b0;
    logic [1599:0] state_out;
    logic [1599:0] state_in = '0;
    logic [511:0]  digest;
    logic          digest_valid;
    logic          digest_ack = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int ps_count    = 0;

    localparam logic [63:0] TOP80 = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;

    keccak_absorb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_bytes     (in_bytes),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .perm_start   (perm_start),
        .perm_done    (perm_done),
        .state_out    (state_out),
        .state_in     (state_in),
        .digest       (digest),
        .digest_valid (digest_valid),
        .digest_ack   (digest_ack)
    );

    always @(negedge clk) if (perm_start === 1'b1) ps_count++;

    function automatic logic [1599:0] mk_k(input logic [63:0] seed);
        logic [1599:0] v;
        for (int i = 0; i < 25; i++) v[64*i +: 64] = seed ^ (64'(i) * 64'h0101_0101_0101_0101);
        return v;
    endfunction

    function automatic int diff_lane(input logic [1599:0] a, input logic [1599:0] b);
        for (int i = 0; i < 25; i++) if (a[64*i +: 64] !== b[64*i +: 64]) return i;
        return 0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; perm_done = 1'b0; digest_ack = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ps_count = 0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic [3:0] b, input logic last);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (in_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout in_ready got %b exp 1", in_ready);
        end
        in_data = d; in_bytes = b; in_last = last; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        $display("xfer data=%h bytes=%0d last=%0b", d, b, last);
    endtask

    task automatic core_done(input logic [1599:0] k, input int delay);
        @(negedge clk);
        repeat (delay) @(negedge clk);
        perm_done = 1'b1; state_in = k;
        @(negedge clk);
        perm_done = 1'b0; state_in = '0;
    endtask

    task automatic ack_digest(input string name);
        digest_ack = 1'b1;
        @(negedge clk);
        digest_ack = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || digest_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_ack ready/valid got %b%b exp 10", name, in_ready, digest_valid);
        end
        vectors++;
        if (state_out !== '0) begin
            miscompares++;
            $display("FAIL %s_ack_clear lane %0d got %h exp 0", name,
                     diff_lane(state_out, '0), state_out[64*diff_lane(state_out, '0) +: 64]);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        vectors++; if (perm_start !== 1'b0) begin miscompares++; $display("FAIL rst_perm_start got %b exp 0", perm_start); end
        vectors++; if (digest_valid !== 1'b0) begin miscompares++; $display("FAIL rst_digest_valid got %b exp 0", digest_valid); end
        vectors++; if (state_out !== '0) begin miscompares++; $display("FAIL rst_state lane %0d got %h exp 0", diff_lane(state_out, '0), state_out[64*diff_lane(state_out, '0) +: 64]); end
        vectors++; if (digest !== '0) begin miscompares++; $display("FAIL rst_digest got %h exp 0", digest); end
    endtask

    task automatic test_empty();
        logic [1599:0] exp, k;
        do_reset();
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b1);
        exp = '0; exp[63:0] = 64'h06; exp[575:512] = TOP80;
        vectors++; if (perm_start !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL empty_start start/ready got %b%b exp 10", perm_start, in_ready); end
        vectors++; if (state_out !== exp) begin miscompares++; $display("FAIL empty_state lane %0d got %h exp %h", diff_lane(state_out, exp), state_out[64*diff_lane(state_out, exp) +: 64], exp[64*diff_lane(state_out, exp) +: 64]); end
        @(negedge clk);
        vectors++; if (perm_start !== 1'b0) begin miscompares++; $display("FAIL empty_pulse perm_start got %b exp 0", perm_start); end
        k = mk_k(64'h1234_5678_9abc_def0);
        core_done(k, 2);
        vectors++; if (digest_valid !== 1'b1 || digest !== k[511:0]) begin miscompares++; $display("FAIL empty_digest valid %b got %h exp %h", digest_valid, digest, k[511:0]); end
        vectors++; if (ps_count !== 1) begin miscompares++; $display("FAIL empty_starts got %0d exp 1", ps_count); end
        ack_digest("empty");
    endtask

    task automatic test_abc();
        logic [1599:0] exp, k;
        do_reset();
        send_word(64'hFFFF_FFFF_FF63_6261, 4'd3, 1'b1);
        exp = '0; exp[63:0] = 64'h0000_0000_0663_6261; exp[575:512] = TOP80;
        vectors++; if (state_out !== exp) begin miscompares++; $display("FAIL abc_state lane %0d got %h exp %h", diff_lane(state_out, exp), state_out[64*diff_lane(state_out, exp) +: 64], exp[64*diff_lane(state_out, exp) +: 64]); end
        k = mk_k(64'hA5A5_0F0F_3C3C_9696);
        core_done(k, 1);
        vectors++; if (digest_valid !== 1'b1 || digest !== k[511:0]) begin miscompares++; $display("FAIL abc_digest valid %b got %h exp %h", digest_valid, digest, k[511:0]); end
        ack_digest("abc");
    endtask

    task automatic test_exact72();
        logic [1599:0] exp, k, k2;
        logic [63:0] w;
        do_reset();
        exp = '0;
        for (int i = 0; i < 9; i++) begin
            w = 64'h0101_0101_0101_0101 * 64'(i + 1);
            exp[64*i +: 64] = w;
            send_word(w, 4'd8, (i == 8));
        end
        vectors++; if (perm_start !== 1'b1 || state_out !== exp) begin miscompares++; $display("FAIL b72_block1 start %b lane %0d got %h exp %h", perm_start, diff_lane(state_out, exp), state_out[64*diff_lane(state_out, exp) +: 64], exp[64*diff_lane(state_out, exp) +: 64]); end
        k = mk_k(64'h0F1E_2D3C_4B5A_6978);
        core_done(k, 3);
        vectors++; if (state_out !== k || perm_start !== 1'b0 || in_ready !== 1'b0 || digest_valid !== 1'b0) begin miscompares++; $display("FAIL b72_pad_state start/ready/valid %b%b%b exp 000 lane %0d got %h exp %h", perm_start, in_ready, digest_valid, diff_lane(state_out, k), state_out[64*diff_lane(state_out, k) +: 64], k[64*diff_lane(state_out, k) +: 64]); end
        @(negedge clk);
        exp = k; exp[63:0] = exp[63:0] ^ 64'h06; exp[575:512] = exp[575:512] ^ TOP80;
        vectors++; if (perm_start !== 1'b1 || state_out !== exp) begin miscompares++; $display("FAIL b72_block2 start %b lane %0d got %h exp %h", perm_start, diff_lane(state_out, exp), state_out[64*diff_lane(state_out, exp) +: 64], exp[64*diff_lane(state_out, exp) +: 64]); end
        k2 = mk_k(64'hFEDC_BA98_7654_3210);
        core_done(k2, 0);
        vectors++; if (digest_valid !== 1'b1 || digest !== k2[511:0]) begin miscompares++; $display("FAIL b72_digest valid %b got %h exp %h", digest_valid, digest, k2[511:0]); end
        vectors++; if (ps_count !== 2) begin miscompares++; $display("FAIL b72_starts got %0d exp 2", ps_count); end
        ack_digest("b72");
    endtask

    task automatic test_boundary();
        logic [1599:0] exp, k;
        logic [63:0] w;
        // 71 bytes: domain and final bits share byte 71.
        do_reset();
        exp = '0;
        for (int i = 0; i < 8; i++) begin
            w = 64'h1111_1111_1111_1111 * 64'(i + 1);
            exp[64*i +: 64] = w;
            send_word(w, 4'd8, 1'b0);
        end
        send_word(64'h7766_5544_3322_1100, 4'd7, 1'b1);
        exp[575:512] = 64'h8666_5544_3322_1100;
        vectors++; if (state_out !== exp) begin miscompares++; $display("FAIL b71_state lane %0d got %h exp %h", diff_lane(state_out, exp), state_out[64*diff_lane(state_out, exp) +: 64], exp[64*diff_lane(state_out, exp) +: 64]); end
        k = mk_k(64'h5555_AAAA_5555_AAAA);
        core_done(k, 0);
        vectors++; if (digest_valid !== 1'b1 || ps_count !== 1) begin miscompares++; $display("FAIL b71_final valid %b starts %0d exp 1 1", digest_valid, ps_count); end
        ack_digest("b71");
        // 32 bytes: domain byte opens lane 4.
        do_reset();
        exp = '0;
        for (int i = 0; i < 4; i++) begin
            w = 64'h0123_4567_89AB_CDEF ^ (64'h1010_1010_1010_1010 * 64'(i));
            exp[64*i +: 64] = w;
            send_word(w, 4'd8, (i == 3));
        end
        exp[319:256] = 64'h06; exp[575:512] = TOP80;
        vectors++; if (state_out !== exp) begin miscompares++; $display("FAIL b32_state lane %0d got %h exp %h", diff_lane(state_out, exp), state_out[64*diff_lane(state_out, exp) +: 64], exp[64*diff_lane(state_out, exp) +: 64]); end
        k = mk_k(64'h0000_FFFF_0000_FFFF);
        core_done(k, 1);
        vectors++; if (digest_valid !== 1'b1 || digest !== k[511:0]) begin miscompares++; $display("FAIL b32_digest valid %b got %h exp %h", digest_valid, digest, k[511:0]); end
        ack_digest("b32");
    endtask

    task automatic test_back_to_back();
        logic [1599:0] exp, k;
        logic [63:0] junk = 64'hDEAD_BEEF_CAFE_F00D;
        int bad = 0;
        do_reset();
        exp = '0;
        for (int i = 0; i < 9; i++) begin
            exp[64*i +: 64] = 64'h0202_0202_0202_0202 * 64'(i + 1);
            send_word(exp[64*i +: 64], 4'd8, 1'b0);
        end
        vectors++; if (perm_start !== 1'b1) begin miscompares++; $display("FAIL bp_start got %b exp 1", perm_start); end
        k = mk_k(64'h1357_9BDF_0246_8ACE);
        in_valid = 1'b1; in_data = junk; in_bytes = 4'd8; in_last = 1'b0;
        perm_done = 1'b1; state_in = ~k;   // coincident with perm_start
        @(negedge clk);
        perm_done = 1'b0; state_in = '0;
        for (int c = 0; c < 24; c++) begin
            if (in_ready !== 1'b0 || state_out !== exp) bad++;
            @(negedge clk);
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL bp_stall bad cycles got %0d exp 0", bad); end
        perm_done = 1'b1; state_in = k;
        @(negedge clk);
        perm_done = 1'b0; state_in = '0;
        vectors++; if (state_out !== k || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_resume ready %b lane %0d got %h exp %h", in_ready, diff_lane(state_out, k), state_out[64*diff_lane(state_out, k) +: 64], k[64*diff_lane(state_out, k) +: 64]); end
        @(negedge clk);
        in_valid = 1'b0;
        exp = k; exp[63:0] = exp[63:0] ^ junk;
        vectors++; if (state_out !== exp) begin miscompares++; $display("FAIL bp_next_lane0 lane %0d got %h exp %h", diff_lane(state_out, exp), state_out[64*diff_lane(state_out, exp) +: 64], exp[64*diff_lane(state_out, exp) +: 64]); end
    endtask

    task automatic test_reset_mid_perm();
        do_reset();
        send_word(64'h0000_0000_0063_6261, 4'd3, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1 || perm_start !== 1'b0 || digest_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_ctrl ready/start/valid got %b%b%b exp 100", in_ready, perm_start, digest_valid); end
        vectors++; if (state_out !== '0 || digest !== '0) begin miscompares++; $display("FAIL midrst_state lane0 got %h exp 0", state_out[63:0]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        perm_done = 1'b1; state_in = mk_k(64'h9999_8888_7777_6666);
        @(negedge clk);
        perm_done = 1'b0; state_in = '0;
        vectors++; if (state_out !== '0 || in_ready !== 1'b1 || digest_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stray ready/valid %b%b exp 10 lane0 got %h exp 0", in_ready, digest_valid, state_out[63:0]); end
    endtask

    task automatic test_ack_gap();
        logic [1599:0] k;
        int bad = 0;
        send_word(64'h0000_0000_0063_6261, 4'd3, 1'b1);
        k = mk_k(64'h2468_ACE0_1357_9BDF);
        core_done(k, 4);
        for (int c = 0; c < 10; c++) begin
            if (digest_valid !== 1'b1 || digest !== k[511:0] || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL gap_hold bad cycles got %0d exp 0", bad); end
        ack_digest("gap");
        send_word(64'h0000_0000_0063_6261, 4'd3, 1'b1);
        vectors++; if (state_out[63:0] !== 64'h0000_0000_0663_6261) begin miscompares++; $display("FAIL gap_next lane0 got %h exp 0000000006636261", state_out[63:0]); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_exact72();
        test_boundary();
        test_back_to_back();
        test_reset_mid_perm();
        test_ack_gap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        miscompares++;
        $display("FAIL global_timeout time got %0t exp below 500000", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keccak_absorb.md
# keccak_absorb

Absorb and padding front-end for the SHA3-512 core. It accepts the message as little-endian 64-bit words over a valid/ready handshake and XORs them into the rate lanes of a locally held 1600-bit state. It applies SHA-3 padding (domain byte 0x06, final bit 0x80) and drives the Keccak-f[1600] permutation core through a start/done handshake. When the final permutation completes, it presents the 512-bit digest. The block writes state in the same lane layout that the theta column-parity logic reads: lane (x,y) occupies bits [64·(5y+x)+63 : 64·(5y+x)], with z as the bit index.

## Interface
- RATE_LANES, 9: rate in 64-bit lanes (576 bits for SHA3-512); lane i = state[64i+63:64i].
- W, 64: lane width; fixed, not to be overridden.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  64  message word, byte 0 = bits [7:0].
- in_bytes  in  4  valid bytes in a last word, 0..8; ignored unless in_last.
- in_last  in  1  marks the final message word.
- in_valid  in  1  word present.
- in_ready  out  1  block accepts a word; transfer = in_valid & in_ready at a rising edge.
- perm_start  out  1  one-cycle pulse requesting a permutation of state_out.
- perm_done  in  1  one-cycle pulse from the core; state_in is valid in that cycle.
- state_out  out  1600  local state register, stable while a permutation runs.
- state_in  in  1600  permuted state from the core.
- digest  out  512  state[511:0] (lanes 0..7), valid while digest_valid.
- digest_valid  out  1  final digest available; held high until acked.
- digest_ack  in  1  consume the digest and clear for the next message.

## Operation
- **States**
  - ABSORB: in_ready=1.
  - PERM: waiting on the core.
  - PAD: pad-only block.
  - DONE: digest_valid=1.
- **Registers**
  - state[1599:0].
  - lane counter 0..8.
  - final flag.
  - pad_pending flag.
- **ABSORB, non-last transfer**
  - state[lane] ^= in_data; lane++.
  - If lane was 8: go to PERM with final=0 and lane=0.
- **ABSORB, last transfer, n=in_bytes, p=8·lane+n**
  - XOR in_data masked to its low n bytes into state[lane].
  - If p<72: XOR 0x06 at byte p of the block and 0x80 at byte 71, combining to 0x86 if p=71. Go to PERM with final=1.
  - If p=72 (n=8, lane=8): set pad_pending, go to PERM with final=0.
  - in_bytes>8 is illegal and is treated as 8.
- **PERM**
  - On perm_done: state <= state_in.
  - Then go to DONE if final=1; to PAD if pad_pending; otherwise to ABSORB.
  - perm_done outside PERM is ignored.
- **PAD** (one cycle)
  - XOR 0x06 into byte 0 of lane 0 and 0x80 into byte 7 of lane 8.
  - Clear pad_pending, set final=1, go to PERM.
- **DONE**
  - digest_valid=1; input is stalled.
  - On digest_ack: state=0, lane=0, flags cleared, go to ABSORB.
- Capacity lanes 9..24 are written only by state_in.

## Timing
- **Reset values**
  - state=0, lane=0, flags=0, ABSORB.
  - in_ready=1, perm_start=0, digest_valid=0, state_out=0, digest=0.
- in_ready and digest_valid are decodes of the registered state; there is no combinational path from in_valid.
- The transfer that fills or closes a block at edge t puts the block in PERM, with perm_start=1 during cycle t..t+1 only.
- state_out reflects the XORed word from edge t onward.
- perm_done is honoured in any PERM cycle after the perm_start cycle. perm_done coincident with perm_start is ignored.
- **Latencies**
  - perm_done sampled at edge u: state_out=state_in from u. The block is in ABSORB, PAD or DONE from u.
  - PAD adds one cycle before the next perm_start.
  - Throughput: 9 words + 1 + core latency + 1 per block.
- digest_ack is honoured only in DONE; the block returns to ABSORB the next cycle.
- rst_n low at any time, including mid-PERM, forces reset values immediately. A perm_done arriving after reset is ignored.

## Test plan
- Empty message: in_last, in_bytes=0 at lane 0.
  - Expect state_out lane0=0x06, lane8=0x8000000000000000, one perm_start.
  - With the reference core model, digest = a69f73cca23a9ac5…281dcd26 (SHA3-512("")).
- "abc": in_data=0x0000000000636261, in_bytes=3, last.
  - Expect lane0=0x0000000006636261.
  - Expect digest = b751850b1a57168a…4eec53f0.
- Exactly 72 bytes: 9 full words, last on lane 8 with in_bytes=8.
  - Expect two perm_starts, PAD visited once.
  - Second block XORs only lane0=0x06, lane8=0x80<<56.
- Boundary pads:
  - 71 bytes (lane 8, in_bytes=7) gives lane8 byte7 = 0x86.
  - 32 bytes (last word full on lane 3) gives lane4 byte0 = 0x06.
- Backpressure: hold in_valid=1 through PERM with a 24-cycle core delay.
  - Expect no transfers, state_out stable, and a perm_done in the perm_start cycle ignored.
- Reset mid-PERM, then an ack gap.
  - Expect all outputs at reset values and a later stray perm_done ignored.
  - Digest held in DONE for 10 cycles until digest_ack, then in_ready=1.
